// File: rtl/alu_exec_stage.sv
// Registered Y86 execute stage: ADD/SUB/AND/XOR with ZF/SF/OF condition codes, 1-cycle latency.
// Backpressure: in_ready drops while a result is held and out_ready is low; held result stays stable.
module alu_exec_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_e,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_e_q, out_e_d;
  logic             out_err_q, out_err_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic [WIDTH-1:0] alu_t;
  logic             alu_of;
  logic             fn_legal;
  logic             accept;

  // Note the Y86 operand order: SUB computes valB - valA.
  always_comb begin
    alu_t    = '0;
    alu_of   = 1'b0;
    fn_legal = 1'b1;
    case (in_fn)
      4'd0: begin
        alu_t  = in_b + in_a;
        alu_of = (in_a[MSB] == in_b[MSB]) && (alu_t[MSB] != in_a[MSB]);
      end
      4'd1: begin
        alu_t  = in_b - in_a;
        alu_of = (in_a[MSB] != in_b[MSB]) && (alu_t[MSB] != in_b[MSB]);
      end
      4'd2: alu_t = in_a & in_b;
      4'd3: alu_t = in_a ^ in_b;
      default: fn_legal = 1'b0;
    endcase
  end

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_e_d     = out_e_q;
    out_err_d   = out_err_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_e_d     = fn_legal ? alu_t : '0;
      out_err_d   = !fn_legal;
      if (fn_legal && in_set_cc) begin
        zf_d = (alu_t == '0);
        sf_d = alu_t[MSB];
        of_d = alu_of;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_e_q     <= '0;
      out_err_q   <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_e_q     <= out_e_d;
      out_err_q   <= out_err_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_e     = out_e_q;
  assign out_err   = out_err_q;
  assign cc_zf     = zf_q;
  assign cc_sf     = sf_q;
  assign cc_of     = of_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes model results, monitor pops on each output transfer.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fn;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_e;
  logic        out_err;
  logic        cc_zf, cc_sf, cc_of;

  typedef struct {
    logic [63:0] e;
    logic        err;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   transfers = 0;
  logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic rand_rdy = 1'b0;

  localparam logic signed [127:0] MAXV = 128'sd9223372036854775807;
  localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

  alu_exec_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn),
    .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_e(out_e), .out_err(out_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: signed arithmetic on wide integers, overflow is "true result out of range".
  function automatic exp_t model(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                                 input logic sc);
    exp_t r;
    logic signed [127:0] sa, sb, s;
    logic ofv;
    sa = $signed(a);
    sb = $signed(b);
    s = '0;
    ofv = 1'b0;
    r.err = 1'b0;
    r.e = '0;
    case (fn)
      4'd0: begin s = sb + sa; r.e = s[63:0]; ofv = (s > MAXV) || (s < MINV); end
      4'd1: begin s = sb - sa; r.e = s[63:0]; ofv = (s > MAXV) || (s < MINV); end
      4'd2: r.e = a & b;
      4'd3: r.e = a ^ b;
      default: r.err = 1'b1;
    endcase
    if (!r.err && sc) begin
      m_zf = (r.e == 64'd0);
      m_sf = r.e[63];
      m_of = ofv;
    end
    r.zf = m_zf;
    r.sf = m_sf;
    r.of = m_of;
    return r;
  endfunction

  task automatic issue(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic sc, output int cycles);
    bit accepted = 0;
    cycles = 0;
    while (!accepted && cycles < 50) begin
      @(negedge clk);
      in_valid = 1'b1; in_fn = fn; in_a = a; in_b = b; in_set_cc = sc;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      cycles++;
      if (in_ready) begin
        accepted = 1;
        exp_q.push_back(model(fn, a, b, sc));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    if (!accepted) check("issue_timeout", 64'd0, 64'd1);
    else begin
      #1 check("latency_out_valid", 64'(out_valid), 64'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: sample after inputs settle, well before the next rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      exp_t x;
      transfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        x = exp_q.pop_front();
        check("out_e", out_e, x.e);
        check("out_err", 64'(out_err), 64'(x.err));
        check("cc", 64'({cc_zf, cc_sf, cc_of}), 64'({x.zf, x.sf, x.of}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [63:0] held;
    logic [63:0] corners [6];
    corners[0] = 64'd0;
    corners[1] = 64'd1;
    corners[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[5] = 64'h0000_0000_0000_0005;

    rst = 1'b1; in_valid = 1'b1; in_fn = 4'd0; in_a = 64'd3; in_b = 64'd4;
    in_set_cc = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_e", out_e, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("post_rst_no_accept", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Directed cases from the test plan.
    issue(4'd2, 64'h7F, 64'h07, 1'b1, cyc);
    issue(4'd3, 64'h7F, 64'h07, 1'b1, cyc);
    issue(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, cyc);
    issue(4'd1, 64'd5, 64'd5, 1'b1, cyc);
    issue(4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, cyc);
    issue(4'd0, 64'd0, 64'd0, 1'b0, cyc);
    issue(4'd7, 64'd9, 64'd2, 1'b1, cyc);
    drain();

    // Backpressure: result held three cycles with a new request waiting.
    out_ready = 1'b0;
    issue(4'd0, 64'd10, 64'd20, 1'b1, cyc);
    held = out_e;
    check("bp_held_value", held, 64'd30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_fn = 4'd1; in_a = 64'($urandom); in_b = 64'($urandom);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_e_stable", out_e, held);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    transfers = 0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 64'(i + 3), 64'(100 - i), 1'b1, cyc);
      check("stream_one_per_cycle", 64'(cyc), 64'd1);
    end
    drain();
    check("stream_transfers", 64'(transfers), 64'd5);

    // Randomized traffic with random downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] fn;
      logic [63:0] a, b;
      int r = $urandom_range(0, 9);
      fn = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
      b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
      issue(fn, a, b, 1'($urandom_range(0, 1)), cyc);
    end
    drain();

    // Reset while a result is held under backpressure.
    out_ready = 1'b0;
    issue(4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, cyc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_fn = 4'd0; in_a = 64'd1; in_b = 64'd1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_e", out_e, 64'd0);
    check("midrst_out_err", 64'(out_err), 64'd0);
    check("midrst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
    exp_q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    issue(4'd1, 64'd2, 64'd2, 1'b0, cyc);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
